// File: rtl/rom_seq_pkg.sv
// Shared types and defaults for the rom1 address sequencer.
package rom_seq_pkg;

   localparam int ADDR_W_DEF    = 4;
   localparam int DATA_W_DEF    = 8;
   localparam int LAST_ADDR_DEF = 15;
   localparam int DWELL_W       = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SEND,
      ST_DWELL,
      ST_DONE
   } state_t;

endpackage

// File: rtl/rom_seq_dwell_cnt.sv
// Loadable down-counter with zero flag; paces the idle gap between ROM fetches.
module rom_seq_dwell_cnt
   import rom_seq_pkg::*;
#(
   parameter int W = DWELL_W
) (
   input  logic         sysclk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/rom_seq_reader.sv
// Walks rom1 through addresses 0..LAST_ADDR, streams each word out on valid/ready
// and keeps a running checksum. Define ROM_SEQ_LOOP_EN to repeat passes until abort.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | address parked at 0, waiting for start
// ST_FETCH | address stable, ROM word captured at the next edge
// ST_SEND  | word presented, waiting for out_ready
// ST_DWELL | idle gap of DWELL_CYCLES before the next fetch
// ST_DONE  | one-cycle done pulse, address returns to 0
module rom_seq_reader
   import rom_seq_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int LAST_ADDR    = LAST_ADDR_DEF,
   parameter int DWELL_CYCLES = 0
) (
   input  logic              sysclk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] checksum
);

   localparam logic [ADDR_W-1:0]  LAST       = ADDR_W'(LAST_ADDR);
   localparam bit                 HAS_DWELL  = (DWELL_CYCLES > 0);
   localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);

   state_t state;
   logic   hs;
   logic   last;
   logic   dwell_load;
   logic   dwell_dec;
   logic   dwell_zero;

   assign hs   = out_valid & out_ready;
   assign last = (rom_addr == LAST);

   // Counter is loaded in the same edge that leaves SEND, so DWELL lasts exactly DWELL_CYCLES.
   assign dwell_load = HAS_DWELL && !abort && (state == ST_SEND) && hs && !last;
   assign dwell_dec  = !abort && (state == ST_DWELL);

   rom_seq_dwell_cnt #(
      .W (DWELL_W)
   ) u_dwell_cnt (
      .sysclk   (sysclk),
      .rst_n    (rst_n),
      .load     (dwell_load),
      .load_val (DWELL_LOAD),
      .dec      (dwell_dec),
      .zero     (dwell_zero)
   );

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         rom_addr  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         checksum  <= '0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state     <= ST_IDLE;
            rom_addr  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  rom_addr <= '0;
                  if (start) begin
                     checksum <= '0;
                     busy     <= 1'b1;
                     state    <= ST_FETCH;
                  end
               end
               ST_FETCH: begin
                  out_data  <= rom_data;
                  out_valid <= 1'b1;
                  state     <= ST_SEND;
               end
               ST_SEND: begin
                  if (hs) begin
                     checksum  <= checksum + out_data;
                     out_valid <= 1'b0;
                     if (last) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                     end else begin
                        rom_addr <= rom_addr + ADDR_W'(1);
                        state    <= HAS_DWELL ? ST_DWELL : ST_FETCH;
                     end
                  end
               end
               ST_DWELL: begin
                  if (dwell_zero) begin
                     state <= ST_FETCH;
                  end
               end
               ST_DONE: begin
                  rom_addr <= '0;
`ifdef ROM_SEQ_LOOP_EN
                  // Completed pass's checksum was visible during the done cycle.
                  checksum <= '0;
                  state    <= ST_FETCH;
`else
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
`endif
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rom_seq_reader.sv
// Bench for rom_seq_reader: two instances (no dwell, dwell of 3) fed by a ROM model data=addr*17.
module tb_rom_seq_reader;

   logic       sysclk;
   logic       rst_n;
   logic       start_s [2];
   logic       abort_s [2];
   logic       ready_s [2];
   logic [3:0] addr_s  [2];
   logic [7:0] rdata_s [2];
   logic [7:0] odata_s [2];
   logic [7:0] csum_s  [2];
   logic       valid_s [2];
   logic       busy_s  [2];
   logic       done_s  [2];

   int nvec = 0;
   int nfail = 0;
   int cyc = 0;
   int acc_cnt [2] = '{0, 0};
   int done_cnt[2] = '{0, 0};
   int hs_cyc  [2] = '{0, 0};
   bit pend    [2] = '{0, 0};
   bit pv      [2] = '{0, 0};
   int gap_exp [2] = '{2, 5};
   logic [7:0] expq[$];

   typedef struct {
      int         d;
      int         stall_word;
      int         stall_len;
      int         abort_word;
      int         start_word;
      int         exp_len;
      logic [7:0] exp_sum;
   } vec_t;

   assign rdata_s[0] = {addr_s[0], addr_s[0]};
   assign rdata_s[1] = {addr_s[1], addr_s[1]};

   rom_seq_reader #(.ADDR_W(4), .DATA_W(8), .LAST_ADDR(15), .DWELL_CYCLES(0)) dut0 (
      .sysclk(sysclk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
      .rom_addr(addr_s[0]), .rom_data(rdata_s[0]), .out_data(odata_s[0]),
      .out_valid(valid_s[0]), .out_ready(ready_s[0]), .busy(busy_s[0]),
      .done(done_s[0]), .checksum(csum_s[0]));

   rom_seq_reader #(.ADDR_W(4), .DATA_W(8), .LAST_ADDR(15), .DWELL_CYCLES(3)) dut1 (
      .sysclk(sysclk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
      .rom_addr(addr_s[1]), .rom_data(rdata_s[1]), .out_data(odata_s[1]),
      .out_valid(valid_s[1]), .out_ready(ready_s[1]), .busy(busy_s[1]),
      .done(done_s[1]), .checksum(csum_s[1]));

   initial begin
      sysclk = 1'b0;
      forever #10 sysclk = ~sysclk;
   end

   always @(posedge sysclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard pop on every handshake, plus fetch-gap and done-pulse tracking.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge sysclk);
         for (int d = 0; d < 2; d++) begin
            if (rst_n && valid_s[d] && ready_s[d] && !abort_s[d]) begin
               if (expq.size() == 0) begin
                  nvec++;
                  nfail++;
                  $display("FAIL sb_empty: dut%0d handshake with data %0h, none expected", d, odata_s[d]);
               end else begin
                  e = expq.pop_front();
                  check("word", odata_s[d], e);
               end
               acc_cnt[d]++;
               if (addr_s[d] == 4'd15) pend[d] = 1'b0;
               else begin
                  pend[d] = 1'b1;
                  hs_cyc[d] = cyc;
               end
            end else if (valid_s[d] && !pv[d] && pend[d]) begin
               check("fetch_gap", cyc - hs_cyc[d], gap_exp[d]);
               pend[d] = 1'b0;
            end
            if (done_s[d]) done_cnt[d]++;
            if (!busy_s[d]) pend[d] = 1'b0;
            pv[d] = valid_s[d];
         end
      end
   end

   task automatic check_zero(input string tag, input int d);
      check({tag, "_addr"},  addr_s[d],  0);
      check({tag, "_data"},  odata_s[d], 0);
      check({tag, "_valid"}, valid_s[d], 0);
      check({tag, "_busy"},  busy_s[d],  0);
      check({tag, "_done"},  done_s[d],  0);
      check({tag, "_csum"},  csum_s[d],  0);
   endtask

`ifdef ROM_SEQ_LOOP_EN
   task automatic loop_test();
      int c0;
      int ndone = 0;
      int len2 = 0;
      for (int i = 0; i < 32; i++) expq.push_back(8'((i % 16) * 17));
      acc_cnt[0] = 0;
      ready_s[0] = 1'b1;
      start_s[0] = 1'b1;
      @(posedge sysclk); #1;
      start_s[0] = 1'b0;
      c0 = cyc;
      for (int c = 0; c < 200 && ndone < 2; c++) begin
         @(posedge sysclk); #1;
         if (done_s[0]) begin
            ndone++;
            if (ndone == 2) len2 = cyc - c0;
            check("loop_csum_at_done", csum_s[0], 8'hF8);
            check("loop_addr_at_done", addr_s[0], 15);
            @(posedge sysclk); #1;
            check("loop_csum_cleared", csum_s[0], 0);
            check("loop_addr_wrap", addr_s[0], 0);
            check("loop_busy", busy_s[0], 1);
            if (ndone == 2) abort_s[0] = 1'b1;
         end
      end
      check("loop_done_count", ndone, 2);
      check("loop_len", len2, 65);
      @(posedge sysclk); #1;
      abort_s[0] = 1'b0;
      check("loop_abort_busy", busy_s[0], 0);
      check("loop_abort_valid", valid_s[0], 0);
      check("loop_words", acc_cnt[0], 32);
      check("loop_sb_left", expq.size(), 0);
      expq.delete();
   endtask
`else
   task automatic run_pass(input vec_t v);
      int d = v.d;
      int stall = 0;
      bit got_done = 1'b0;
      bit aborted = 1'b0;
      int len = 0;
      int c0;
      int dc0;
      for (int i = 0; i < 16; i++) expq.push_back(8'(i * 17));
      acc_cnt[d] = 0;
      dc0 = done_cnt[d];
      ready_s[d] = 1'b1;
      start_s[d] = 1'b1;
      @(posedge sysclk); #1;
      start_s[d] = 1'b0;
      c0 = cyc;
      for (int c = 0; c < 600 && !got_done && !aborted; c++) begin
         @(posedge sysclk); #1;
         start_s[d] = 1'b0;
         abort_s[d] = 1'b0;
         if (done_s[d]) begin
            got_done = 1'b1;
            len = cyc - c0;
         end else if (valid_s[d] && acc_cnt[d] == v.abort_word) begin
            ready_s[d] = 1'b0;
            abort_s[d] = 1'b1;
            aborted = 1'b1;
         end else begin
            if (stall < v.stall_len && acc_cnt[d] == v.stall_word && (stall > 0 || valid_s[d])) begin
               ready_s[d] = 1'b0;
               stall++;
               check("bp_valid", valid_s[d], 1);
               check("bp_data", odata_s[d], 8'(v.stall_word * 17));
               check("bp_addr", addr_s[d], 4'(v.stall_word));
            end else begin
               ready_s[d] = 1'b1;
            end
            if (valid_s[d] && acc_cnt[d] == v.start_word) start_s[d] = 1'b1;
         end
      end
      if (aborted) begin
         @(posedge sysclk); #1;
         abort_s[d] = 1'b0;
         ready_s[d] = 1'b1;
         check("abort_busy", busy_s[d], 0);
         check("abort_valid", valid_s[d], 0);
         check("abort_addr", addr_s[d], 0);
         check("abort_csum", csum_s[d], v.exp_sum);
         repeat (3) @(posedge sysclk);
         #1;
         check("abort_no_done", done_cnt[d] - dc0, 0);
      end else begin
         check("pass_done_seen", got_done, 1);
         check("pass_len", len, v.exp_len);
         check("pass_csum", csum_s[d], v.exp_sum);
         check("pass_words", acc_cnt[d], 16);
         check("pass_sb_left", expq.size(), 0);
         @(posedge sysclk); #1;
         check("done_width", done_s[d], 0);
         check("end_busy", busy_s[d], 0);
         check("end_addr", addr_s[d], 0);
         check("csum_held", csum_s[d], v.exp_sum);
         check("done_count", done_cnt[d] - dc0, 1);
      end
      expq.delete();
   endtask

   task automatic reset_mid_dwell(input vec_t clean);
      for (int i = 0; i < 16; i++) expq.push_back(8'(i * 17));
      acc_cnt[1] = 0;
      ready_s[1] = 1'b1;
      start_s[1] = 1'b1;
      @(posedge sysclk); #1;
      start_s[1] = 1'b0;
      for (int c = 0; c < 100 && acc_cnt[1] < 2; c++) begin
         @(posedge sysclk); #1;
      end
      check("dwell_reached", acc_cnt[1], 2);
      check("in_dwell", {busy_s[1], valid_s[1]}, 2'b10);
      #4 rst_n = 1'b0;
      #1 check_zero("async_rst", 1);
      #3;
      @(negedge sysclk);
      rst_n = 1'b1;
      expq.delete();
      @(posedge sysclk); #1;
      run_pass(clean);
   endtask
`endif

   initial begin
`ifndef ROM_SEQ_LOOP_EN
      vec_t tbl[5];
      tbl[0] = '{0, -1, 0, -1, -1, 32, 8'hF8};
      tbl[1] = '{0,  3, 5, -1, -1, 37, 8'hF8};
      tbl[2] = '{0, -1, 0,  7, -1,  0, 8'h65};
      tbl[3] = '{0, -1, 0, -1, -1, 32, 8'hF8};
      tbl[4] = '{1, -1, 0, -1,  5, 77, 8'hF8};
`endif
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         start_s[d] = 1'b0;
         abort_s[d] = 1'b0;
         ready_s[d] = 1'b1;
      end
      #5;
      check_zero("reset0", 0);
      check_zero("reset1", 1);
      repeat (3) @(posedge sysclk);
      #1 rst_n = 1'b1;
      @(posedge sysclk); #1;
      check("idle_busy", busy_s[0], 0);
      check("idle_addr", addr_s[0], 0);

      start_s[0] = 1'b1;
      abort_s[0] = 1'b1;
      @(posedge sysclk); #1;
      start_s[0] = 1'b0;
      abort_s[0] = 1'b0;
      check("start_abort_busy", busy_s[0], 0);
      @(posedge sysclk); #1;
      check("start_abort_valid", valid_s[0], 0);

`ifdef ROM_SEQ_LOOP_EN
      loop_test();
`else
      for (int i = 0; i < 5; i++) run_pass(tbl[i]);
      reset_mid_dwell(tbl[4]);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
